// File: rtl/sdram_wr_buffer.sv
// Byte FIFO feeding the SDRAM write engine: buffers upstream bytes and raises a
// one-cycle wr_trig per full burst, re-arming only after that burst is drained.
module sdram_wr_buffer #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic [7:0]        din,
  input  logic              din_vld,
  output logic              din_rdy,
  input  logic              wfifo_rd_en,
  output logic [7:0]        wfifo_rd_data,
  output logic              wr_trig,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] BURST_C = (ADDR_W + 1)'(BURST_LEN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_TRIG = 3'b010,
    ST_WAIT = 3'b100
  } state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   cnt_next;
  logic [ADDR_W:0]   pop_cnt_reg;
  logic [ADDR_W:0]   pop_cnt_next;
  logic [7:0]        rd_data_reg;
  logic              ovf_reg;
  logic              udf_reg;
  state_t            state_reg;
  state_t            state_next;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (cnt_reg == DEPTH_C);
  assign empty = (cnt_reg == '0);
  assign push  = din_vld & ~full;
  assign pop   = wfifo_rd_en & ~empty;

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge sclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + (ADDR_W + 1)'(1);
      2'b01:   cnt_next = cnt_reg - (ADDR_W + 1)'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    pop_cnt_next = pop_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cnt_reg >= BURST_C) begin
          state_next = ST_TRIG;
        end
      end
      ST_TRIG: begin
        pop_cnt_next = '0;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (pop) begin
          pop_cnt_next = pop_cnt_reg + (ADDR_W + 1)'(1);
        end
        // Leaving as the last pop lands gives the tightest trigger spacing.
        if (pop_cnt_next == BURST_C) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      cnt_reg     <= '0;
      pop_cnt_reg <= '0;
      rd_data_reg <= '0;
      ovf_reg     <= 1'b0;
      udf_reg     <= 1'b0;
      state_reg   <= ST_IDLE;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + ADDR_W'(1);
        rd_data_reg <= mem[rd_ptr_reg];
      end
      if (din_vld & full) begin
        ovf_reg <= 1'b1;
      end
      if (wfifo_rd_en & empty) begin
        udf_reg <= 1'b1;
      end
      cnt_reg     <= cnt_next;
      pop_cnt_reg <= pop_cnt_next;
      state_reg   <= state_next;
    end
  end

  assign din_rdy       = ~full;
  assign fifo_cnt      = cnt_reg;
  assign wfifo_rd_data = rd_data_reg;
  assign wr_trig       = (state_reg == ST_TRIG);
  assign ovf           = ovf_reg;
  assign udf           = udf_reg;

endmodule

// File: doc/sdram_wr_buffer.md
# sdram_wr_buffer

Byte-wide synchronous FIFO and write-trigger generator on the write side of the SDRAM controller top. Upstream byte producers (UART RX, test pattern source) push bytes in. The block pulses `wr_trig` once a full burst is buffered, then serves `wfifo_rd_en` pops from the SDRAM write engine. It re-arms only after that burst has been drained.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least `2*BURST_LEN`.
- `ADDR_W`, 4: log2(`DEPTH`).
- `BURST_LEN`, 4: bytes consumed per SDRAM write burst.
- `sclk`  in  1  system clock; all logic on its rising edge.
- `s_rst`  in  1  reset; synchronous, active-high.
- `din`  in  8  byte from upstream.
- `din_vld`  in  1  `din` is valid this cycle.
- `din_rdy`  out  1  FIFO not full; a push occurs on `din_vld & din_rdy`.
- `wfifo_rd_en`  in  1  pop request from the SDRAM write engine.
- `wfifo_rd_data`  out  8  registered pop data.
- `wr_trig`  out  1  one-cycle burst-available pulse to the SDRAM write engine.
- `fifo_cnt`  out  `ADDR_W+1`  current occupancy, 0..`DEPTH`.
- `ovf`  out  1  sticky: push attempted while full.
- `udf`  out  1  sticky: pop attempted while empty.

## Operation
- **Storage:** `DEPTH`×8 array with `ADDR_W`-bit write and read pointers that wrap modulo `DEPTH`. `fifo_cnt` is tracked separately.
- **full / empty:** full = (`fifo_cnt` == `DEPTH`); empty = (`fifo_cnt` == 0). `din_rdy` = !full.
- **Push:** on `din_vld & !full`, write `din` at the write pointer and increment the pointer.
- **Push while full:** `din_vld & full` discards the byte and sets `ovf`. This applies even if a pop occurs in the same cycle.
- **Pop:** on `wfifo_rd_en & !empty`, register array[read pointer] into `wfifo_rd_data` and increment the read pointer.
- **Pop while empty:** `wfifo_rd_en & empty` leaves `wfifo_rd_data` and the pointer unchanged and sets `udf`. This applies even if a push occurs in the same cycle.
- **Count update:** `fifo_cnt` changes +1 on a push-only cycle, −1 on a pop-only cycle, and holds when both or neither occur.
- **Trigger FSM**, one-hot, three states:
  - IDLE: go to TRIG when `fifo_cnt >= BURST_LEN`.
  - TRIG: `wr_trig` = 1 for exactly this cycle; clear the pop counter; go to WAIT unconditionally.
  - WAIT: count accepted pops (`wfifo_rd_en & !empty`). Go to IDLE in the cycle after the counter reaches `BURST_LEN`.
  - Illegal state: return to IDLE.
- **Pop counter:** `ADDR_W+1` bits wide. Pops seen in IDLE or TRIG are still served from the FIFO but are not counted.
- **Pushes** are accepted in every state; the FSM never blocks upstream.
- **Back-to-back bursts:** if `fifo_cnt >= BURST_LEN` on return to IDLE, TRIG follows on the next cycle.

## Timing
- **Reset values:** while `s_rst` is sampled high, both pointers, `fifo_cnt`, `wfifo_rd_data`, `ovf`, `udf` and the pop counter are 0; the FSM is in IDLE; `wr_trig` = 0; `din_rdy` = 1.
- **Reset mid-operation:** reset mid-burst discards all stored data with no partial drain. Array contents need no reset.
- **Pop data latency:** `wfifo_rd_data` is valid 1 cycle after the accepted `wfifo_rd_en`. This is normal (non-show-ahead) FIFO timing and the write engine samples it one cycle after its pop request.
- **Registered status:** `fifo_cnt`, `din_rdy` and the flags reflect a push or pop from the cycle after it.
- **Push-to-trigger latency:** when the push that makes `fifo_cnt` reach `BURST_LEN` is accepted in cycle N:
  - `fifo_cnt` updates in N+1;
  - IDLE→TRIG is taken in N+1;
  - `wr_trig` is high in N+2.
- **Minimum spacing** between `wr_trig` pulses is `BURST_LEN`+2 cycles, reached with consecutive pops immediately after the trigger.
- **Full boundary:** in the cycle `fifo_cnt` == `DEPTH` with a simultaneous pop, `din_rdy` is still 0. `din_rdy` returns high the following cycle.
- **Wrap-around:** pointer wrap from `DEPTH`−1 to 0 is seamless; no cycle is lost.

## Test plan
- **Reset:** hold `s_rst` 3 cycles with `din_vld` = 1 → `fifo_cnt` = 0, `wr_trig` = 0, `din_rdy` = 1, flags 0, no pushes recorded.
- **Single burst:**
  - Stimulus: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles (last in cycle N), then pop 4 cycles starting 1 cycle after `wr_trig`.
  - Required: `wr_trig` high only in N+2; `wfifo_rd_data` = 0x11, 0x22, 0x33, 0x44, each one cycle after its pop; `fifo_cnt` ends at 0; FSM in IDLE.
- **Full and overflow:**
  - Push 16 bytes 0x00..0x0F → `din_rdy` = 0 and `fifo_cnt` = 16.
  - Push 0xFF → byte dropped and `ovf` = 1.
  - Drain 16 → data 0x00..0x0F in order; `ovf` stays 1.
- **Underflow:** pop while empty → `udf` = 1, `wfifo_rd_data` unchanged, `fifo_cnt` stays 0, no trigger.
- **Simultaneous push/pop with wrap:**
  - Preload 8 bytes, then push and pop together for 20 cycles.
  - Required: `fifo_cnt` stays 8; output sequence is continuous across the pointer wrap; `wr_trig` pulses every 6 cycles with continuous pops.
- **Reset mid-burst:** assert `s_rst` in WAIT after 2 of 4 pops → FSM returns to IDLE, `fifo_cnt` = 0, and no `wr_trig` pulse until 4 fresh pushes.
